// File: rtl/instr_pkg.sv
// Shared opcode constants, instruction field positions and fetch FSM state type.
package instr_pkg;

  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_CAP,
    ST_VALID,
    ST_HALT
  } fetch_state_e;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational field extraction and opcode classification of one instruction word.
module instr_decoder
  import instr_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output logic [3:0]         opcode_o,
  output logic [2:0]         rd_o,
  output logic [2:0]         rs1_o,
  output logic [2:0]         rs2_o,
  output logic               is_add_o,
  output logic               is_sub_o,
  output logic               is_halt_o,
  output logic               illegal_o
);

  // The low three bits carry no meaning for any opcode.
  logic unused_low_bits;
  assign unused_low_bits = ^instr_i[RS2_LSB-1:0];

  assign opcode_o  = instr_i[OPC_LSB +: 4];
  assign rd_o      = instr_i[RD_LSB  +: 3];
  assign rs1_o     = instr_i[RS1_LSB +: 3];
  assign rs2_o     = instr_i[RS2_LSB +: 3];

  assign is_add_o  = (opcode_o == OP_ADD);
  assign is_sub_o  = (opcode_o == OP_SUB);
  assign is_halt_o = (opcode_o == OP_HALT);
  assign illegal_o = !(is_add_o || is_sub_o || is_halt_o);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch FSM: three-cycle fetch from synchronous instruction memory, ready/valid hand-off.
// Define INSTR_FETCH_LOADER_EN to add the Load_Valid/Load_Data program loader writing memory from IDLE.
module instr_fetch_unit
  import instr_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] Redirect_Addr,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic              Mem_Wren,
  output logic [DATA_W-1:0] Mem_Din,
  input  logic [DATA_W-1:0] Mem_Q,
  output logic              Instr_Valid,
  input  logic              Instr_Ready,
  output logic [ADDR_W-1:0] PC,
  output logic [3:0]        Opcode,
  output logic [2:0]        Rd,
  output logic [2:0]        Rs1,
  output logic [2:0]        Rs2,
  output logic              Is_Add,
  output logic              Is_Sub,
  output logic              Is_Halt,
  output logic              Illegal,
  output logic              Halt
`ifdef INSTR_FETCH_LOADER_EN
  ,
  input  logic              Load_Valid,
  input  logic [DATA_W-1:0] Load_Data
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fp_q, fp_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              active;

  assign active = (state_q == ST_REQ) || (state_q == ST_CAP) || (state_q == ST_VALID);

  always_comb begin
    state_d = state_q;
    fp_d    = fp_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Redirect) fp_d = Redirect_Addr;
        if (Start)    state_d = ST_REQ;
      end
      ST_HALT: begin
        if (Redirect)   fp_d = Redirect_Addr;
        else if (Start) fp_d = '0;
        if (Start)      state_d = ST_REQ;
      end
      ST_REQ:  state_d = ST_CAP;
      ST_CAP: begin
        state_d = ST_VALID;
        ir_d    = Mem_Q;
        pc_d    = fp_q;
        fp_d    = fp_q + ADDR_W'(1);
      end
      ST_VALID: begin
        if (Instr_Ready) state_d = Is_Halt ? ST_HALT : ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
    // Redirect wins over capture and over HALT entry; the old IR/PC simply stay unpresented.
    if (Redirect && active) begin
      state_d = ST_REQ;
      fp_d    = Redirect_Addr;
      pc_d    = pc_q;
      ir_d    = ir_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      fp_q    <= '0;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      fp_q    <= fp_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

`ifdef INSTR_FETCH_LOADER_EN
  logic [3:0] ld_q;
  logic       ld_wr;

  assign ld_wr = (state_q == ST_IDLE) && Load_Valid && !Reset;

  always_ff @(posedge Clock) begin
    if (Reset)      ld_q <= '0;
    else if (ld_wr) ld_q <= ld_q + 4'd1;
  end

  assign Mem_Address = ld_wr ? ADDR_W'(ld_q) : fp_q;
  assign Mem_Wren    = ld_wr;
  assign Mem_Din     = ld_wr ? Load_Data : '0;
`else
  assign Mem_Address = fp_q;
  assign Mem_Wren    = 1'b0;
  assign Mem_Din     = '0;
`endif

  assign Instr_Valid = (state_q == ST_VALID);
  assign Halt        = (state_q == ST_HALT);
  assign PC          = pc_q;

  instr_decoder u_dec (
    .instr_i   (ir_q[INSTR_W-1:0]),
    .opcode_o  (Opcode),
    .rd_o      (Rd),
    .rs1_o     (Rs1),
    .rs2_o     (Rs2),
    .is_add_o  (Is_Add),
    .is_sub_o  (Is_Sub),
    .is_halt_o (Is_Halt),
    .illegal_o (Illegal)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: vector table, directed corner sequences, then random vs. a transaction model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam int AW = 4;
  localparam int DW = 16;

  logic          Clock = 1'b0;
  logic          Reset, Start, Redirect, Instr_Ready;
  logic [AW-1:0] Redirect_Addr, Mem_Address, PC;
  logic          Mem_Wren, Instr_Valid, Is_Add, Is_Sub, Is_Halt, Illegal, Halt;
  logic [DW-1:0] Mem_Din, Mem_Q;
  logic [3:0]    Opcode;
  logic [2:0]    Rd, Rs1, Rs2;
`ifdef INSTR_FETCH_LOADER_EN
  logic          Load_Valid;
  logic [DW-1:0] Load_Data;
`endif

  always #5 Clock = ~Clock;

  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Redirect(Redirect),
    .Redirect_Addr(Redirect_Addr), .Mem_Address(Mem_Address), .Mem_Wren(Mem_Wren),
    .Mem_Din(Mem_Din), .Mem_Q(Mem_Q), .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready),
    .PC(PC), .Opcode(Opcode), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Is_Add(Is_Add),
    .Is_Sub(Is_Sub), .Is_Halt(Is_Halt), .Illegal(Illegal), .Halt(Halt)
`ifdef INSTR_FETCH_LOADER_EN
    , .Load_Valid(Load_Valid), .Load_Data(Load_Data)
`endif
  );

  // Synchronous instruction memory: data one cycle after the address.
  logic          mem_reload;
  logic [DW-1:0] init_mem [16];
  logic [DW-1:0] mem [16];
  always @(posedge Clock) begin
    if (mem_reload)    mem <= init_mem;
    else if (Mem_Wren) mem[Mem_Address] <= Mem_Din;
    Mem_Q <= mem[Mem_Address];
  end

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] word;
    logic [3:0]  opc;
    logic [2:0]  rd, rs1, rs2;
    logic [3:0]  flags;   // {Is_Add, Is_Sub, Is_Halt, Illegal}
  } vec_t;
  vec_t tbl [8];

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 20 && Instr_Valid !== 1'b1; n++) tick();
    if (Instr_Valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_valid timeout actual=0 required=1 at %0t", $time);
    end
  endtask

  task automatic check_vec(input vec_t v);
    chk("valid", Instr_Valid, 1);
    chk("pc", PC, v.addr);
    chk("opcode", Opcode, v.opc);
    chk("rd", Rd, v.rd);
    chk("rs1", Rs1, v.rs1);
    chk("rs2", Rs2, v.rs2);
    chk("flags", {Is_Add, Is_Sub, Is_Halt, Illegal}, v.flags);
  endtask

  // Transaction-level reference: idle/halted flags, a fetch countdown and the presented word.
  bit          m_idle, m_halt, m_pres;
  int          m_cnt, m_fp, m_pc;
  logic [15:0] m_ir;

  initial begin
    tbl[0] = '{4'd0,  16'h0298, 4'h0, 3'd1, 3'd2, 3'd3, 4'b1000};
    tbl[1] = '{4'd1,  16'h1FFF, 4'h1, 3'd7, 3'd7, 3'd7, 4'b0100};
    tbl[2] = '{4'd2,  16'h0000, 4'h0, 3'd0, 3'd0, 3'd0, 4'b1000};
    tbl[3] = '{4'd3,  16'hF000, 4'hF, 3'd0, 3'd0, 3'd0, 4'b0010};
    tbl[4] = '{4'd4,  16'h5123, 4'h5, 3'd0, 3'd4, 3'd4, 4'b0001};
    tbl[5] = '{4'd5,  16'hE7FF, 4'hE, 3'd3, 3'd7, 3'd7, 4'b0001};
    tbl[6] = '{4'd6,  16'h2A54, 4'h2, 3'd5, 3'd1, 3'd2, 4'b0001};
    tbl[7] = '{4'd15, 16'h5ABC, 4'h5, 3'd5, 3'd2, 3'd7, 4'b0001};
    for (int i = 0; i < 16; i++) init_mem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) init_mem[tbl[i].addr] = tbl[i].word;

    Reset = 1; Start = 0; Redirect = 0; Redirect_Addr = 0; Instr_Ready = 0; mem_reload = 1;
`ifdef INSTR_FETCH_LOADER_EN
    Load_Valid = 0; Load_Data = 0;
`endif
    @(negedge Clock);
    tick(); tick();
    mem_reload = 0; Reset = 0;
    chk("rst_valid", Instr_Valid, 0);
    chk("rst_halt", Halt, 0);
    chk("rst_pc", PC, 0);
    chk("rst_opcode", Opcode, 0);
    chk("rst_flags", {Is_Add, Is_Sub, Is_Halt, Illegal}, 4'b1000);
    chk("rst_wren", Mem_Wren, 0);
    chk("rst_din", Mem_Din, 0);
    chk("rst_addr", Mem_Address, 0);

    // Start sampled at edge N: valid visible to a consumer sampling at edge N+3.
    Instr_Ready = 1; Start = 1; tick(); Start = 0;
    chk("lat_req_valid", Instr_Valid, 0);
    chk("lat_req_addr", Mem_Address, 0);
    tick(); chk("lat_cap_valid", Instr_Valid, 0);
    tick(); chk("lat_valid", Instr_Valid, 1);
    check_vec(tbl[0]);
    for (int i = 1; i < 4; i++) begin
      tick(); wait_valid(); check_vec(tbl[i]);
    end

    // HALT accepted: unit parks with the pointer past the halt word.
    tick();
    chk("halt_entry", Halt, 1);
    chk("halt_valid", Instr_Valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_hold", Halt, 1);
      chk("halt_addr", Mem_Address, 4);
    end
    Start = 1; tick(); Start = 0;
    chk("halt_exit", Halt, 0);
    wait_valid(); check_vec(tbl[0]);

    // Redirect coincident with handshake, then sequential fetch.
    Redirect = 1; Redirect_Addr = 4; tick(); Redirect = 0;
    chk("redir_hs_valid", Instr_Valid, 0);
    wait_valid(); check_vec(tbl[4]);
    tick(); wait_valid(); check_vec(tbl[5]);
    tick(); wait_valid(); check_vec(tbl[6]);

    // Redirect drops an unaccepted instruction; stall at address 15 then wrap.
    Instr_Ready = 0; Redirect = 1; Redirect_Addr = 15; tick(); Redirect = 0;
    chk("redir_drop", Instr_Valid, 0);
    wait_valid(); check_vec(tbl[7]);
    for (int i = 0; i < 5; i++) begin
      tick(); check_vec(tbl[7]);
    end
    Instr_Ready = 1; tick();
    chk("acc_c1", Instr_Valid, 0);
    tick(); chk("acc_c2", Instr_Valid, 0);
    tick(); chk("acc_c3", Instr_Valid, 1);
    check_vec(tbl[0]);

    // Redirect during CAP: the address-1 word is never presented.
    tick(); tick();
    Redirect = 1; Redirect_Addr = 9; tick(); Redirect = 0;
    chk("cap_redir_valid", Instr_Valid, 0);
    wait_valid();
    chk("cap_redir_pc", PC, 9);
    chk("cap_redir_flags", {Is_Add, Is_Sub, Is_Halt, Illegal}, 4'b1000);

    // Reset mid-handshake and mid-fetch.
    Instr_Ready = 0; Reset = 1; tick(); Reset = 0;
    chk("rstv_valid", Instr_Valid, 0);
    chk("rstv_pc", PC, 0);
    chk("rstv_opcode", Opcode, 0);
    chk("rstv_halt", Halt, 0);
    Start = 1; tick(); Start = 0; tick();
    Reset = 1; tick(); Reset = 0;
    chk("rstf_valid", Instr_Valid, 0);
    tick(); tick(); tick();
    chk("rstf_idle", Instr_Valid, 0);

`ifdef INSTR_FETCH_LOADER_EN
    Load_Valid = 1; Load_Data = 16'h1040;
    chk("ld0_wren", Mem_Wren, 1); chk("ld0_addr", Mem_Address, 0); chk("ld0_din", Mem_Din, 16'h1040);
    tick(); Load_Data = 16'h0000;
    chk("ld1_wren", Mem_Wren, 1); chk("ld1_addr", Mem_Address, 1); chk("ld1_din", Mem_Din, 0);
    tick(); Load_Data = 16'hF000;
    chk("ld2_wren", Mem_Wren, 1); chk("ld2_addr", Mem_Address, 2); chk("ld2_din", Mem_Din, 16'hF000);
    tick(); Load_Valid = 0;
    chk("ld_off_wren", Mem_Wren, 0);
    Instr_Ready = 1; Start = 1; tick(); Start = 0;
    wait_valid();
    chk("ldp0_pc", PC, 0);
    chk("ldp0_flags", {Is_Add, Is_Sub, Is_Halt, Illegal}, 4'b0100);
    chk("ldp0_regs", {Rd, Rs1, Rs2}, {3'd0, 3'd1, 3'd0});
    tick(); wait_valid();
    chk("ldp1_pc", PC, 1);
    chk("ldp1_flags", {Is_Add, Is_Sub, Is_Halt, Illegal}, 4'b1000);
    tick(); wait_valid();
    chk("ldp2_pc", PC, 2);
    chk("ldp2_flags", {Is_Add, Is_Sub, Is_Halt, Illegal}, 4'b0010);
    tick(); chk("ld_halt", Halt, 1);
    Start = 1; tick(); Start = 0; Instr_Ready = 0;
    wait_valid();
    Reset = 1; tick(); Reset = 0;
    chk("ld_rst_valid", Instr_Valid, 0);
`endif

    // Random phase against the reference model.
    for (int i = 0; i < 16; i++) init_mem[i] = 16'($urandom);
    mem_reload = 1; Reset = 1; Redirect = 0; Start = 0; tick();
    mem_reload = 0; Reset = 0;
    m_idle = 1; m_halt = 0; m_pres = 0; m_cnt = 0; m_fp = 0; m_pc = 0; m_ir = 0;
    for (int c = 0; c < 3000; c++) begin
      bit st, rdr, rdy, rst;
      int ra;
      logic [31:0] exp;
      int opc;
      rst = ($urandom_range(0, 149) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rdr = !st && ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      ra  = $urandom_range(0, 15);
      Reset = rst; Start = st; Redirect = rdr; Redirect_Addr = AW'(ra); Instr_Ready = rdy;
      tick();
      if (rst) begin
        m_idle = 1; m_halt = 0; m_pres = 0; m_cnt = 0; m_fp = 0; m_pc = 0; m_ir = 0;
      end else if (m_idle || m_halt) begin
        if (rdr) m_fp = ra;
        if (st) begin
          if (m_halt) m_fp = 0;
          m_idle = 0; m_halt = 0; m_cnt = 2;
        end
      end else if (rdr) begin
        m_pres = 0; m_cnt = 2; m_fp = ra;
      end else if (m_pres) begin
        if (rdy) begin
          m_pres = 0;
          if ((m_ir >> 12) == 15) m_halt = 1;
          else m_cnt = 2;
        end
      end else begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_pres = 1; m_pc = m_fp; m_ir = init_mem[m_fp]; m_fp = (m_fp + 1) % 16;
        end
      end
      opc = int'(m_ir >> 12);
      exp = {5'd0, m_pres, m_halt, 4'(m_fp), 4'(m_pc), 4'(opc),
             3'((m_ir >> 9) & 7), 3'((m_ir >> 6) & 7), 3'((m_ir >> 3) & 7),
             opc == 0, opc == 1, opc == 15, (opc >= 2 && opc <= 14)};
      chk("rand", {5'd0, Instr_Valid, Halt, Mem_Address, PC, Opcode, Rd, Rs1, Rs2,
                   Is_Add, Is_Sub, Is_Halt, Illegal}, exp);
    end
    Reset = 0; Start = 0; Redirect = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameters SHALL be, one per line:
 - ADDR_W, default 4, instruction memory address width (16 words).
 - DATA_W, default 16, instruction width.
REQ-002 Ports SHALL be, one per line:
 - Clock  in  1  clock, all logic on rising edge.
 - Reset  in  1  reset, synchronous, active-high.
 - Start  in  1  begin fetching from PC (from IDLE or HALT).
 - Redirect  in  1  load PC with Redirect_Addr and restart fetch.
 - Redirect_Addr  in  ADDR_W  redirect target.
 - Mem_Address  out  ADDR_W  instruction memory address.
 - Mem_Wren  out  1  instruction memory write enable.
 - Mem_Din  out  DATA_W  instruction memory write data.
 - Mem_Q  in  DATA_W  instruction memory read data, valid one cycle after the address.
 - Instr_Valid  out  1  decoded instruction available.
 - Instr_Ready  in  1  consumer accepts the instruction.
 - PC  out  ADDR_W  address of the presented instruction.
 - Opcode  out  4  Instr[15:12].
 - Rd  out  3  Instr[11:9].
 - Rs1  out  3  Instr[8:6].
 - Rs2  out  3  Instr[5:3].
 - Is_Add, Is_Sub, Is_Halt, Illegal  out  1 each  decode flags.
 - Halt  out  1  unit stopped on a HALT instruction.
 - Load_Valid, Load_Data[DATA_W]  in  program loader; present only with LOADER_EN.

Function
REQ-003 The FSM SHALL have the states IDLE, REQ, CAP, VALID and HALT.
REQ-004 Transitions SHALL be:
 - IDLE -> REQ on Start.
 - REQ -> CAP unconditionally.
 - CAP -> VALID unconditionally.
 - VALID -> REQ on Instr_Valid&&Instr_Ready when Is_Halt=0.
 - VALID -> HALT on Instr_Valid&&Instr_Ready when Is_Halt=1.
 - HALT -> REQ on Start, with the fetch pointer set to 0.
REQ-005 Mem_Address SHALL equal the fetch pointer in REQ, CAP and VALID; Mem_Wren SHALL be 0 in these states.
REQ-006 In CAP the unit SHALL register Mem_Q into the instruction register, register the fetch pointer into PC, and increment the fetch pointer modulo 2^ADDR_W (15 wraps to 0).
REQ-007 Instr_Valid SHALL be 1 only in VALID; Start sampled at edge N SHALL give Instr_Valid=1 from edge N+3.
REQ-008 While Instr_Valid=1 and Instr_Ready=0, Instr_Valid, PC and all decode outputs SHALL hold stable.
REQ-009 Decode outputs SHALL be combinational functions of the instruction register:
 - Is_Add = (Opcode==4'h0).
 - Is_Sub = (Opcode==4'h1).
 - Is_Halt = (Opcode==4'hF).
 - Illegal = 1 for every other opcode (4'h2..4'hE); illegal instructions SHALL still be presented.
 - Instr[2:0] SHALL be ignored.
REQ-010 Redirect sampled in REQ, CAP or VALID SHALL:
 - load the fetch pointer with Redirect_Addr;
 - go to REQ;
 - drop any unaccepted instruction (Instr_Valid=0 next cycle).
REQ-011 Redirect in IDLE or HALT SHALL load the fetch pointer only; the state SHALL NOT change.
REQ-012 Redirect coincident with a VALID handshake SHALL complete the handshake and fetch next from Redirect_Addr; redirect SHALL override HALT entry.
REQ-013 Start outside IDLE/HALT SHALL be ignored.
REQ-014 Halt SHALL be 1 exactly while in HALT.

Reset
REQ-015 Reset SHALL take priority over every other input and SHALL set, at the next edge:
 - state IDLE;
 - fetch pointer, PC, instruction register and loader pointer to 0;
 - Instr_Valid, Halt and Mem_Wren to 0.
 An instruction register of 0 decodes as Is_Add=1.
REQ-016 Reset asserted mid-fetch or mid-handshake SHALL discard the instruction with no partial output.

Configuration
REQ-017 Macro INSTR_FETCH_LOADER_EN SHALL add the Load_Valid and Load_Data ports and a 4-bit loader pointer.
REQ-018 With INSTR_FETCH_LOADER_EN, Load_Valid in IDLE SHALL drive Mem_Wren=1, Mem_Address=loader pointer and Mem_Din=Load_Data in the same cycle. The loader pointer SHALL increment with wrap 15->0. Load_Valid SHALL be ignored in every other state. Start together with Load_Valid SHALL perform the write and then enter REQ.
REQ-019 Without INSTR_FETCH_LOADER_EN, the Load ports SHALL be absent, Mem_Wren SHALL be tied to 0 and Mem_Din SHALL be tied to 0.

Structure
REQ-020 Shared package instr_pkg SHALL hold:
 - OP_ADD=4'h0, OP_SUB=4'h1, OP_HALT=4'hF;
 - instruction field bit positions;
 - the FSM state typedef.
REQ-021 Decode SHALL be the combinational sub-module instr_decoder, instantiated once.

Verification
REQ-022 Directed scenarios, one line each:
 - Reset, then Start, with the memory at its reset contents and Ready=1 -> PC=0, Opcode=0, Rd=1, Rs1=2, Rs2=3, Is_Add=1; then PC=1 with Is_Sub=1; then PC=2 with an all-zero instruction (Is_Add=1, Rd=Rs1=Rs2=0).
 - Ready=0 for 5 cycles in VALID -> all outputs held; accepted on the first cycle Ready=1; next Instr_Valid 3 cycles later.
 - Word 16'hF000 at address 3, Ready=1 -> Is_Halt with PC=3, then Halt=1 and no further Mem_Address change until Start; Start then refetches from 0.
 - Redirect=1, Redirect_Addr=9 during CAP -> that instruction is never presented; next presented PC=9.
 - Fetch at address 15 -> next PC=0 (wrap); Opcode 4'h5 -> Illegal=1, Is_Add=Is_Sub=Is_Halt=0.
 - With LOADER_EN: 3 Load_Valid writes of 16'h1040, 16'h0000, 16'hF000, then Start -> Is_Sub (Rd=0, Rs1=1, Rs2=0), Is_Add, Is_Halt, then Halt=1; Reset asserted mid-VALID -> Instr_Valid=0 next edge.
